hpm_counter_bank: RTL and testbench
===================================

# hpm_counter_bank

Parametrised hardware performance monitor. It provides NUM_CNT independent wide counters. Each counter is assigned to one of NUM_EVENTS CPU trace probes, or to the cycle clock, through its own config register. The block adds per-counter enables, software preload, tear-free 64-bit reads through a high-word shadow, sticky overflow flags and a maskable overflow interrupt. It sits on the MMIO bus beside the CPU and takes its probes from the CPU trace port.

## Interface
- NUM_CNT, 4: number of counters; legal range 1..8.
- CNT_W, 48: counter width; legal range 33..64.
- NUM_EVENTS, 8: number of probe inputs; legal range 1..255.
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cs  in  1  MMIO chip select.
- we  in  1  MMIO write strobe; qualified by cs.
- addr  in  8  byte address; bits [1:0] are ignored.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational; 0 when cs=0.
- events  in  NUM_EVENTS  probe pulses; one count per cycle high; already synchronous to clk.
- irq  out  1  registered level interrupt.

## Operation
Register map:
- 0x00 CTRL
  - bit0 GEN: global enable.
  - bit1 CLR: clear all counters; self-clearing; reads back 0 one cycle after the write.
- 0x04 OVF: bit i is the sticky overflow flag for counter i; write 1 to clear.
- 0x08 IRQEN: bit i unmasks OVF[i].
- Counter n at base 0x20+0x10·n:
  - +0x0 CFG: bits[7:0] SEL, bit8 EN.
  - +0x4 LO: live bits[31:0].
  - +0x8 HI: upper CNT_W-32 bits, zero-extended.
  - +0xC: reserved; reads 0, writes ignored.
- Any unmapped address, or counter n ≥ NUM_CNT, reads 0 and ignores writes.

Event select:
- SEL=0: the cycle clock (always counts).
- SEL=k, 1 ≤ k ≤ NUM_EVENTS: events[k-1].
- SEL > NUM_EVENTS: never counts.

Counting:
- Counter i increments by 1 in a cycle when GEN & EN_i & (selected source = 1).
- Arithmetic is modulo 2^CNT_W.

Overflow:
- An increment from all-ones wraps the counter to 0 and sets OVF[i].
- irq is registered from the previous cycle: irq = |(OVF & IRQEN[NUM_CNT-1:0]).

Reads:
- A read of LO (cs=1, we=0) returns the live low word.
- In the same edge it latches the live upper bits into that counter's HI shadow.
- A read of HI returns the shadow, never the live value.
- Software reads LO then HI to obtain a coherent value.

Writes:
- A write to LO loads bits[31:0].
- A write to HI loads the upper bits from wdata[CNT_W-33:0] and also updates the shadow.

Priority per counter, highest first: CLR → software write to LO/HI → increment.
- CLR zeroes all counters and shadows. It does not touch CFG, OVF or IRQEN.
- A software write in the same cycle as an increment: the write wins and the increment is lost.

OVF priority:
- A hardware overflow set beats a W1C clear in the same cycle; the flag stays 1.

Reset values:
- All registers, counters, shadows and OVF are 0; irq=0; rdata=0.
- Reset mid-count aborts immediately (asynchronous).

## Timing
- The event is sampled at edge t; the count is visible on rdata in the cycle after t.
- CTRL/CFG write at edge t: the new enable/select governs increments sampled from edge t+1 onward.
- CLR written at edge t:
  - counters are zero after edge t+1;
  - events at edge t+1 are not counted;
  - counting resumes at edge t+2 if GEN=1.
- Overflow wrap at edge t:
  - OVF[i]=1 after edge t;
  - irq=1 after edge t+1 if IRQEN[i]=1.
- W1C of OVF at edge t: irq falls after edge t+1.
- rdata is combinational in the cs cycle. The bus has zero wait states.

## Test plan
- Reset, then read every address → all 0, irq=0. Write CTRL=0x1 and CFG0=0x100 (SEL=0, EN) for 10 cycles, stop, read LO0 → 10 (±1 per the write-edge rule); HI0 → 0.
- CFG1=0x103 (events[2]), GEN=1, pulse events[2] on 7 of 20 cycles, events[0] toggling → LO1=7; counters with EN=0 stay 0; SEL=0xFF → 0.
- Preload HI0=0xFFFF, LO0=0xFFFFFFFE with CNT_W=48, cycle counting, IRQEN=1 → after 2 counts the counter is 0, OVF=0x1, irq rises one cycle later. W1C OVF=1 → irq drops next cycle. Overflow coinciding with the W1C write → OVF stays 1.
- Preload LO2=0xFFFFFFFF, HI2=0x5, count cycles, read LO2 then HI2 across the carry → the HI2 value is the one captured at the LO2 read (0x5 when LO read 0xFFFFFFFF, 0x6 when LO read 0x0), never a mixed value.
- Counter running; write CTRL=0x3 → all counters 0, CTRL reads 0x1 next cycle, CFG/IRQEN unchanged. Write LO0 in the same cycle as an event → LO0 equals the written value.
- Assert rst_n low mid-count for 1 cycle → all registers 0 immediately; no counting until GEN is rewritten.

Source files
------------

// File: rtl/hpm_counter_bank.sv
// rtl/hpm_counter_bank.sv - MMIO-mapped bank of wide performance counters with
// per-counter event select, HI shadow for tear-free reads and overflow interrupt.
module hpm_counter_bank #(
   parameter int NUM_CNT    = 4,
   parameter int CNT_W      = 48,
   parameter int NUM_EVENTS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  we,
   input  logic [7:0]            addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   input  logic [NUM_EVENTS-1:0] events,
   output logic                  irq
);

   localparam int HI_W = CNT_W - 32;

   logic               gen_q;
   logic               clr_q;
   logic [NUM_CNT-1:0] ovf_q;
   logic [NUM_CNT-1:0] irqen_q;
   logic [NUM_CNT-1:0] ovf_set;
   logic [NUM_CNT-1:0] ovf_clr;
   logic               wr;
   logic               w_ctrl;
   logic               w_ovf;
   logic               w_irqen;
   logic [255:0]       src_vec;
   logic               unused_addr;

   logic [CNT_W-1:0]   cnt_rd [NUM_CNT];
   logic [HI_W-1:0]    shd_rd [NUM_CNT];
   logic [8:0]         cfg_rd [NUM_CNT];

   assign wr          = cs && we;
   assign w_ctrl      = wr && (addr[7:2] == 6'h00);
   assign w_ovf       = wr && (addr[7:2] == 6'h01);
   assign w_irqen     = wr && (addr[7:2] == 6'h02);
   assign ovf_clr     = w_ovf ? wdata[NUM_CNT-1:0] : '0;
   assign unused_addr = ^addr[1:0];

   // Source table indexed directly by SEL: entry 0 is the cycle clock,
   // entries past the last probe stay 0 so out-of-range selects never count.
   always_comb begin
      src_vec = '0;
      src_vec[NUM_EVENTS:0] = {events, 1'b1};
   end

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [HI_W-1:0]  shd_q;
      logic [7:0]       sel_q;
      logic             en_q;
      logic             hit;
      logic             w_cfg;
      logic             w_lo;
      logic             w_hi;
      logic             r_lo;
      logic             inc;

      assign hit   = cs && (addr[7:4] == 4'(i + 2));
      assign w_cfg = hit && we && (addr[3:2] == 2'd0);
      assign w_lo  = hit && we && (addr[3:2] == 2'd1);
      assign w_hi  = hit && we && (addr[3:2] == 2'd2);
      assign r_lo  = hit && !we && (addr[3:2] == 2'd1);
      assign inc   = gen_q && en_q && src_vec[sel_q];

      // A wrap only counts when the increment actually lands.
      assign ovf_set[i] = inc && !clr_q && !w_lo && !w_hi && (&cnt_q);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            shd_q <= '0;
            sel_q <= '0;
            en_q  <= 1'b0;
         end else begin
            if (w_cfg) begin
               sel_q <= wdata[7:0];
               en_q  <= wdata[8];
            end
            if (clr_q) begin
               cnt_q <= '0;
               shd_q <= '0;
            end else if (w_lo) begin
               cnt_q[31:0] <= wdata;
            end else if (w_hi) begin
               cnt_q[CNT_W-1:32] <= wdata[HI_W-1:0];
               shd_q             <= wdata[HI_W-1:0];
            end else begin
               if (r_lo) shd_q <= cnt_q[CNT_W-1:32];
               if (inc)  cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end

      assign cnt_rd[i] = cnt_q;
      assign shd_rd[i] = shd_q;
      assign cfg_rd[i] = {en_q, sel_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gen_q   <= 1'b0;
         clr_q   <= 1'b0;
         ovf_q   <= '0;
         irqen_q <= '0;
         irq     <= 1'b0;
      end else begin
         clr_q <= w_ctrl && wdata[1];
         if (w_ctrl)  gen_q   <= wdata[0];
         if (w_irqen) irqen_q <= wdata[NUM_CNT-1:0];
         ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
         irq   <= |(ovf_q & irqen_q);
      end
   end

   always_comb begin
      rdata = '0;
      if (cs) begin
         case (addr[7:2])
            6'h00:   rdata = {30'b0, clr_q, gen_q};
            6'h01:   rdata = 32'(ovf_q);
            6'h02:   rdata = 32'(irqen_q);
            default: rdata = '0;
         endcase
         for (int i = 0; i < NUM_CNT; i++) begin
            if (addr[7:4] == 4'(i + 2)) begin
               case (addr[3:2])
                  2'd0:    rdata = 32'(cfg_rd[i]);
                  2'd1:    rdata = cnt_rd[i][31:0];
                  2'd2:    rdata = 32'(shd_rd[i]);
                  default: rdata = '0;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb/tb_hpm_counter_bank.sv - directed bench for hpm_counter_bank with a
// cycle-level behavioural model compared on every falling edge.
module tb_hpm_counter_bank;

   localparam int NC = 4;
   localparam int CW = 48;
   localparam int NE = 8;
   localparam longint unsigned MASK  = (64'd1 << CW) - 1;
   localparam longint unsigned HMASK = (64'd1 << (CW - 32)) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cs;
   logic          we;
   logic [7:0]    addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic [NE-1:0] events;
   logic          irq;

   int n_assert = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   hpm_counter_bank #(.NUM_CNT(NC), .CNT_W(CW), .NUM_EVENTS(NE)) dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata), .events(events), .irq(irq)
   );

   always #5 clk = ~clk;

   longint unsigned m_cnt [NC];
   longint unsigned m_shd [NC];
   logic [7:0]      m_sel [NC];
   bit              m_en  [NC];
   bit              m_gen, m_clr, m_irq;
   bit [NC-1:0]     m_ovf, m_irqen;

   function automatic void m_reset();
      for (int i = 0; i < NC; i++) begin
         m_cnt[i] = 0; m_shd[i] = 0; m_sel[i] = 0; m_en[i] = 0;
      end
      m_gen = 0; m_clr = 0; m_irq = 0; m_ovf = 0; m_irqen = 0;
   endfunction

   function automatic bit m_src(input logic [7:0] s);
      if (s == 0) return 1'b1;
      if (int'(s) <= NE) return events[int'(s) - 1];
      return 1'b0;
   endfunction

   // One clock edge of the register map, written from the programmer's view.
   function automatic void m_step();
      bit wr, rd, hit, inc;
      int a, off;
      bit [NC-1:0] set = '0;
      wr = cs && we;
      rd = cs && !we;
      a  = int'(addr) & 'hFC;
      m_irq = |(m_ovf & m_irqen);
      for (int i = 0; i < NC; i++) begin
         hit = (a >= 'h20) && (((a - 'h20) >> 4) == i);
         off = a & 'hC;
         inc = m_gen && m_en[i] && m_src(m_sel[i]);
         if (m_clr) begin
            m_cnt[i] = 0;
            m_shd[i] = 0;
         end else if (hit && wr && off == 4) begin
            m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | longint'(wdata);
         end else if (hit && wr && off == 8) begin
            m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF) | ((longint'(wdata) & HMASK) << 32);
            m_shd[i] = longint'(wdata) & HMASK;
         end else begin
            if (hit && rd && off == 4) m_shd[i] = m_cnt[i] >> 32;
            if (inc) begin
               m_cnt[i] = (m_cnt[i] + 1) & MASK;
               if (m_cnt[i] == 0) set[i] = 1'b1;
            end
         end
         if (hit && wr && off == 0) begin
            m_sel[i] = wdata[7:0];
            m_en[i]  = wdata[8];
         end
      end
      m_ovf = (m_ovf & ~((wr && a == 4) ? wdata[NC-1:0] : '0)) | set;
      if (wr && a == 8) m_irqen = wdata[NC-1:0];
      if (wr && a == 0) begin
         m_gen = wdata[0];
         m_clr = wdata[1];
      end else begin
         m_clr = 1'b0;
      end
   endfunction

   function automatic logic [31:0] m_rdata();
      int a, n;
      if (!cs) return 32'd0;
      a = int'(addr) & 'hFC;
      if (a == 0) return {30'b0, m_clr, m_gen};
      if (a == 4) return 32'(m_ovf);
      if (a == 8) return 32'(m_irqen);
      if (a >= 'h20) begin
         n = (a - 'h20) >> 4;
         if (n < NC) begin
            case (a & 'hC)
               0:       return {23'b0, m_en[n], m_sel[n]};
               4:       return 32'(m_cnt[n]);
               8:       return 32'(m_shd[n]);
               default: return 32'd0;
            endcase
         end
      end
      return 32'd0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else        m_step();
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_rdata", rdata, m_rdata());
         chk("model_irq", 32'(irq), 32'(m_irq));
      end
   end

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
      cs = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      chk(name, rdata, exp);
      @(posedge clk); #1;
      cs = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   bit [19:0] pat = 20'b1010_0110_0001_0100_1000;

   initial begin
      cs = 0; we = 0; addr = 0; wdata = 0; events = 0; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check_en = 1'b1;

      for (int a = 0; a < 256; a += 4) rd("reset_read", 8'(a), 32'd0);
      chk("reset_irq", 32'(irq), 32'd0);

      // cycle counting for exactly 10 enabled edges
      wr(8'h00, 32'h1);
      wr(8'h20, 32'h100);
      idle(9);
      wr(8'h20, 32'h000);
      rd("lo0_cycles", 8'h24, 32'd10);
      rd("hi0_cycles", 8'h28, 32'd0);

      // event counting
      wr(8'h30, 32'h103);
      wr(8'h40, 32'h001);
      wr(8'h50, 32'h1FF);
      for (int k = 0; k < 20; k++) begin
         events = NE'((k & 1) | (int'(pat[k]) << 2));
         @(posedge clk); #1;
      end
      events = '0;
      rd("lo1_events", 8'h34, 32'd7);
      rd("lo2_disabled", 8'h44, 32'd0);
      rd("lo3_sel_ff", 8'h54, 32'd0);

      // overflow and interrupt
      wr(8'h30, 32'h003);
      wr(8'h08, 32'h1);
      wr(8'h28, 32'hFFFF);
      wr(8'h24, 32'hFFFF_FFFE);
      wr(8'h20, 32'h100);
      idle(1);
      wr(8'h20, 32'h000);
      chk("irq_before", 32'(irq), 32'd0);
      rd("ovf_set", 8'h04, 32'h1);
      chk("irq_rise", 32'(irq), 32'd1);
      rd("lo0_wrapped", 8'h24, 32'd0);
      rd("hi0_wrapped", 8'h28, 32'd0);
      wr(8'h04, 32'h1);
      chk("irq_hold", 32'(irq), 32'd1);
      idle(1);
      chk("irq_fall", 32'(irq), 32'd0);

      // wrap in the same edge as a W1C
      wr(8'h28, 32'hFFFF);
      wr(8'h24, 32'hFFFF_FFFF);
      wr(8'h20, 32'h100);
      wr(8'h04, 32'h1);
      wr(8'h20, 32'h000);
      rd("ovf_beats_w1c", 8'h04, 32'h1);
      wr(8'h04, 32'h1);
      rd("ovf_cleared", 8'h04, 32'h0);

      // coherent LO/HI reads across the carry
      wr(8'h44, 32'hFFFF_FFFF);
      wr(8'h48, 32'h5);
      wr(8'h40, 32'h100);
      rd("lo2_pre_carry", 8'h44, 32'hFFFF_FFFF);
      rd("hi2_pre_carry", 8'h48, 32'h5);
      wr(8'h40, 32'h001);
      wr(8'h44, 32'hFFFF_FFFE);
      wr(8'h48, 32'h5);
      wr(8'h40, 32'h100);
      idle(2);
      rd("lo2_post_carry", 8'h44, 32'h0);
      rd("hi2_post_carry", 8'h48, 32'h6);

      // CLR and write-beats-increment
      wr(8'h20, 32'h100);
      idle(3);
      wr(8'h00, 32'h3);
      rd("ctrl_clr_pending", 8'h00, 32'h3);
      rd("ctrl_clr_done", 8'h00, 32'h1);
      rd("lo2_after_clr", 8'h44, 32'd1);
      rd("cfg2_kept", 8'h40, 32'h100);
      rd("irqen_kept", 8'h08, 32'h1);
      rd("cfg0_kept", 8'h20, 32'h100);
      wr(8'h24, 32'h1234);
      rd("lo0_write_wins", 8'h24, 32'h1234);

      // asynchronous reset mid-count
      rst_n = 1'b0;
      #1;
      chk("rst_irq", 32'(irq), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd("rst_ctrl", 8'h00, 32'd0);
      rd("rst_cfg2", 8'h40, 32'd0);
      rd("rst_irqen", 8'h08, 32'd0);
      rd("rst_lo2", 8'h44, 32'd0);
      idle(3);
      rd("rst_no_count", 8'h44, 32'd0);
      wr(8'h00, 32'h1);
      wr(8'h40, 32'h100);
      idle(3);
      rd("restart_count", 8'h44, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
